// File: rtl/io_pulse_gen.sv
// io_pulse_gen: per-button synchronizer, debouncer and press-to-single-cycle-pulse converter.
// Define IO_PULSE_GEN_ACTIVE_LOW_EN for active-low keys (0 = pressed).
module io_pulse_gen #(
  parameter int WIDTH       = 4,
  parameter int LEN         = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] buttons,
  output logic [WIDTH-1:0] button_pulse
);
  localparam int CW = $clog2(LEN + 1);
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] sq [SYNC_STAGES];
  logic [WIDTH-1:0] sync;
`ifdef IO_PULSE_GEN_ACTIVE_LOW_EN
  assign din = ~buttons;
`else
  assign din = buttons;
`endif
  assign sync = sq[SYNC_STAGES-1];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < SYNC_STAGES; s++) sq[s] <= '0;
    end else begin
      sq[0] <= din;
      for (int s = 1; s < SYNC_STAGES; s++) sq[s] <= sq[s-1];
    end
  end
  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    logic          state;
    logic [CW-1:0] cnt;
    logic          pulse;
    logic          diff;
    logic          hit;
    assign diff = sync[i] != state;
    assign hit  = cnt == CW'(LEN - 1);
    // a new level is accepted only after LEN consecutive differing samples
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state <= 1'b0;
        cnt   <= '0;
        pulse <= 1'b0;
      end else begin
        state <= diff && hit ? sync[i] : state;
        cnt   <= diff && !hit ? cnt + 1'b1 : '0;
        pulse <= diff && hit && sync[i];
      end
    end
    assign button_pulse[i] = pulse;
  end
endmodule

// File: tb/tb_io_pulse_gen.sv
// tb_io_pulse_gen: directed self-checking bench for io_pulse_gen with default parameters.
module tb_io_pulse_gen;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] buttons = 4'h0;
  logic [3:0] button_pulse;
  int         n_chk = 0;
  int         n_fail = 0;
`ifdef IO_PULSE_GEN_ACTIVE_LOW_EN
  localparam logic [3:0] INV = 4'hF;
`else
  localparam logic [3:0] INV = 4'h0;
`endif

  io_pulse_gen dut (
    .clk(clk),
    .reset_n(reset_n),
    .buttons(buttons),
    .button_pulse(button_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] exp);
    n_chk++;
    assert (button_pulse === exp)
    else begin
      n_fail++;
      $error("FAIL %s: button_pulse=%h expected %h", tag, button_pulse, exp);
    end
  endtask

  // drive logical level b, clock one edge, then check the pulse just after that edge
  task automatic tick(input string tag, input logic [3:0] b, input logic [3:0] exp);
    buttons = b ^ INV;
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  task automatic idle(input string tag, input int n);
    for (int j = 0; j < n; j++) tick(tag, 4'h0, 4'h0);
  endtask

  initial begin
    buttons = 4'hF ^ INV;
    #1;
    chk("reset_immediate", 4'h0);
    for (int j = 0; j < 3; j++) tick("reset_hold", 4'hF, 4'h0);
    reset_n = 1'b1;
    tick("rel_k0", 4'hF, 4'h0);
    tick("rel_k1", 4'hF, 4'h0);
    tick("rel_k2", 4'hF, 4'h0);
    tick("rel_k3", 4'hF, 4'hF);
    for (int j = 0; j < 4; j++) tick("rel_held", 4'hF, 4'h0);
    idle("rel_drop", 6);

    tick("clean_k0", 4'h1, 4'h0);
    tick("clean_k1", 4'h1, 4'h0);
    tick("clean_k2", 4'h1, 4'h0);
    tick("clean_k3", 4'h1, 4'h1);
    for (int j = 0; j < 6; j++) tick("clean_held", 4'h1, 4'h0);
    idle("clean_drop", 6);

    for (int i = 0; i < 4; i++) begin
      logic [3:0] b;
      b = 4'(1 << i);
      tick("bounce_1", b, 4'h0);
      tick("bounce_0", 4'h0, 4'h0);
      tick("bounce_k0", b, 4'h0);
      tick("bounce_k1", b, 4'h0);
      tick("bounce_k2", b, 4'h0);
      tick("bounce_k3", b, b);
      for (int j = 0; j < 5; j++) tick("bounce_held", b, 4'h0);
      idle("bounce_drop", 6);
    end

    tick("glitch_1", 4'h4, 4'h0);
    idle("glitch_after", 8);

    tick("press1_k0", 4'h2, 4'h0);
    tick("press1_k1", 4'h2, 4'h0);
    tick("press1_k2", 4'h2, 4'h0);
    tick("press1_k3", 4'h2, 4'h2);
    tick("press1_held", 4'h2, 4'h0);
    idle("release1", 10);
    tick("repress1_k0", 4'h2, 4'h0);
    tick("repress1_k1", 4'h2, 4'h0);
    tick("repress1_k2", 4'h2, 4'h0);
    tick("repress1_k3", 4'h2, 4'h2);
    for (int j = 0; j < 3; j++) tick("repress1_held", 4'h2, 4'h0);
    idle("repress1_drop", 6);

    tick("simul_k0", 4'hF, 4'h0);
    tick("simul_k1", 4'hF, 4'h0);
    tick("simul_k2", 4'hF, 4'h0);
    tick("simul_k3", 4'hF, 4'hF);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_reset_clears", 4'h0);
    tick("reset2_hold", 4'hF, 4'h0);
    tick("reset2_hold", 4'hF, 4'h0);
    reset_n = 1'b1;
    tick("rel2_k0", 4'hF, 4'h0);
    tick("rel2_k1", 4'hF, 4'h0);
    tick("rel2_k2", 4'hF, 4'h0);
    tick("rel2_k3", 4'hF, 4'hF);
    for (int j = 0; j < 3; j++) tick("rel2_held", 4'hF, 4'h0);
    idle("final_drop", 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
